// File: rtl/draw_sequencer.sv
// Round-robin draw-window dispatcher: latches per-channel requests and serves each with a HOLD-cycle DRAW window.
// Optional `DRAW_RETRIGGER_EN: a same-channel request during ACTIVE restarts the window count.
module draw_sequencer #(
    parameter int CH    = 3,
    parameter int CH_W  = 2,
    parameter int CNT_W = 8,
    parameter int HOLD  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [CH-1:0]    REQ,
    input  logic             STALL,
    output logic             DRAW,
    output logic [CH_W-1:0]  CH_SEL,
    output logic [CNT_W-1:0] Count,
    output logic             BUSY,
    output logic             DONE,
    output logic [CH-1:0]    PEND
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD - 1);

    state_t           state, state_n;
    logic [CH_W-1:0]  last_grant, last_n, ch_n;
    logic [CNT_W-1:0] cnt_n;
    logic [CH-1:0]    pend_n, set_m, clr_m;
    logic             retrig;

    // First pending channel strictly after base, wrapping at CH-1 -> 0
    function automatic logic [CH_W-1:0] rr_pick(input logic [CH-1:0] p,
                                                input logic [CH_W-1:0] base);
        logic [CH_W-1:0] g;
        logic            found;
        int              idx;
        g     = '0;
        found = 1'b0;
        for (int i = 1; i <= CH; i++) begin
            idx = (int'(base) + i) % CH;
            if (!found && p[idx]) begin
                g     = CH_W'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        state_n = state;
        ch_n    = CH_SEL;
        cnt_n   = Count;
        last_n  = last_grant;
        clr_m   = '0;
        retrig  = 1'b0;
`ifdef DRAW_RETRIGGER_EN
        retrig  = (state == S_ACTIVE) && REQ[CH_SEL];
`else
        retrig  = 1'b0;
`endif
        set_m = REQ;
        if (retrig)
            set_m[CH_SEL] = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (|PEND) begin
                    state_n = S_SETUP;
                    ch_n    = rr_pick(PEND, last_grant);
                    cnt_n   = '0;
                end
            end
            S_SETUP: begin
                state_n       = S_ACTIVE;
                clr_m[CH_SEL] = 1'b1;
            end
            S_ACTIVE: begin
                if (retrig)
                    cnt_n = '0;
                else if (!STALL) begin
                    if (Count == LAST_CNT)
                        state_n = S_DONE;
                    else
                        cnt_n = Count + CNT_W'(1);
                end
            end
            S_DONE: begin
                last_n = CH_SEL;
                if (|PEND) begin
                    state_n = S_SETUP;
                    ch_n    = rr_pick(PEND, CH_SEL);
                    cnt_n   = '0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // a new request wins over the grant clear
        pend_n = (PEND & ~clr_m) | set_m;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            CH_SEL     <= '0;
            Count      <= '0;
            PEND       <= '0;
            last_grant <= CH_W'(CH - 1);
        end else begin
            state      <= state_n;
            CH_SEL     <= ch_n;
            Count      <= cnt_n;
            PEND       <= pend_n;
            last_grant <= last_n;
        end
    end

    assign DRAW = (state == S_ACTIVE);
    assign DONE = (state == S_DONE);
    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboard bench for draw_sequencer: a behavioural model predicts each window and
// a negedge monitor compares DUT outputs and completed windows against it.
module tb_draw_sequencer;

    localparam int CH    = 3;
    localparam int CH_W  = 2;
    localparam int CNT_W = 8;
    localparam int HOLD  = 5;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [CH-1:0]    REQ = '0;
    logic             STALL = 1'b0;
    logic             DRAW;
    logic [CH_W-1:0]  CH_SEL;
    logic [CNT_W-1:0] Count;
    logic             BUSY;
    logic             DONE;
    logic [CH-1:0]    PEND;

    draw_sequencer #(
        .CH(CH), .CH_W(CH_W), .CNT_W(CNT_W), .HOLD(HOLD)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .STALL(STALL),
        .DRAW(DRAW), .CH_SEL(CH_SEL), .Count(Count),
        .BUSY(BUSY), .DONE(DONE), .PEND(PEND)
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int ch;
        int len;
    } win_t;

    win_t exp_q[$];

    // model phases: waiting, setup gap, drawing, finishing
    localparam int P_WAIT = 0;
    localparam int P_GAP  = 1;
    localparam int P_DRAW = 2;
    localparam int P_FIN  = 3;

    int            m_ph, m_ch, m_last, m_cnt, m_len;
    logic [CH-1:0] m_pend, po, clr, setm;
    bit            rt;
    bit            mon_on = 0;
    int            drawn  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [CH-1:0] p, input int last);
        for (int k = 1; k <= CH; k++) begin
            int c;
            c = (last + k) % CH;
            if (p[c]) return c;
        end
        return 0;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_ph   = P_WAIT;
            m_ch   = 0;
            m_last = CH - 1;
            m_cnt  = 0;
            m_len  = 0;
            m_pend = '0;
            exp_q.delete();
        end else begin
            po   = m_pend;
            clr  = '0;
            setm = REQ;
            rt   = 0;
            case (m_ph)
                P_WAIT: begin
                    if (po != 0) begin
                        m_ch = pick(po, m_last);
                        m_ph = P_GAP;
                    end
                end
                P_GAP: begin
                    clr[m_ch] = 1'b1;
                    m_ph  = P_DRAW;
                    m_cnt = 0;
                    m_len = 0;
                end
                P_DRAW: begin
                    m_len++;
`ifdef DRAW_RETRIGGER_EN
                    rt = REQ[m_ch];
`endif
                    if (rt) begin
                        setm[m_ch] = 1'b0;
                        m_cnt = 0;
                    end else if (!STALL) begin
                        if (m_cnt == HOLD - 1) begin
                            win_t w;
                            w.ch  = m_ch;
                            w.len = m_len;
                            exp_q.push_back(w);
                            m_ph = P_FIN;
                        end else begin
                            m_cnt++;
                        end
                    end
                end
                default: begin
                    m_last = m_ch;
                    if (po != 0) begin
                        m_ch = pick(po, m_last);
                        m_ph = P_GAP;
                    end else begin
                        m_ph = P_WAIT;
                    end
                end
            endcase
            m_pend = (po & ~clr) | setm;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            drawn = 0;
        end else if (mon_on) begin
            chk("draw", int'(DRAW), int'(m_ph == P_DRAW));
            chk("busy", int'(BUSY), int'(m_ph != P_WAIT));
            chk("done", int'(DONE), int'(m_ph == P_FIN));
            chk("pend", int'(PEND), int'(m_pend));
            if (m_ph == P_DRAW) chk("count", int'(Count), m_cnt);
            if (m_ph == P_GAP) chk("count_setup", int'(Count), 0);
            if (m_ph != P_WAIT) chk("ch_sel", int'(CH_SEL), m_ch);
            if (DRAW) drawn++;
            if (DONE) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got DONE expected none at %0t", $time);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    chk("win_ch", int'(CH_SEL), e.ch);
                    chk("win_len", drawn, e.len);
                end
                drawn = 0;
            end
        end
    end

    task automatic step(input logic [CH-1:0] r, input logic s);
        REQ   = r;
        STALL = s;
        @(posedge CLK);
        #2;
        REQ   = '0;
        STALL = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0);
    endtask

    task automatic wait_cnt(input int c);
        bit hit;
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            if (DRAW && int'(Count) == c) begin
                hit = 1;
                break;
            end
            @(posedge CLK);
            #2;
        end
        if (!hit) begin
            compared++;
            mismatched++;
            $display("FAIL wait_count: got timeout expected Count=%0d", c);
        end
    endtask

    initial begin
        #3;
        chk("rst_draw", int'(DRAW), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_count", int'(Count), 0);
        chk("rst_chsel", int'(CH_SEL), 0);
        chk("rst_pend", int'(PEND), 0);
        @(posedge CLK);
        #2;
        RST    = 1'b0;
        mon_on = 1;

        step(3'b010, 1'b0);
        idle(10);

        step(3'b111, 1'b0);
        idle(25);

        step(3'b101, 1'b0);
        for (int i = 0; i < 30; i++) step(3'b001, 1'b0);
        idle(15);

        step(3'b001, 1'b0);
        wait_cnt(2);
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        idle(10);

        step(3'b010, 1'b0);
        wait_cnt(3);
        step(3'b010, 1'b0);
        idle(20);

        step(3'b010, 1'b0);
        step(3'b100, 1'b0);
        wait_cnt(2);
        RST = 1'b1;
        #1;
        chk("async_draw", int'(DRAW), 0);
        chk("async_busy", int'(BUSY), 0);
        chk("async_count", int'(Count), 0);
        chk("async_pend", int'(PEND), 0);
        #4;
        RST = 1'b0;
        @(posedge CLK);
        #2;
        step(3'b010, 1'b0);
        idle(10);

        for (int i = 0; i < 400; i++) begin
            logic [CH-1:0] r;
            for (int b = 0; b < CH; b++) r[b] = ($urandom_range(0, 7) == 0);
            step(r, $urandom_range(0, 3) == 0);
        end
        idle(60);

        chk("drain_queue", exp_q.size(), 0);
        chk("drain_busy", int'(BUSY), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
